// File: rtl/deco_pkg.sv
// Shared types and widths for the decode-stage immediate path.
package deco_pkg;

  localparam int INTEGER_WIDTH = 32;
  localparam int IMM_WIDTH     = 19;

  typedef enum logic [1:0] {
    SEXT  = 2'b00,
    ZEXT  = 2'b01,
    UPPER = 2'b10,
    NONE  = 2'b11
  } imm_sel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } stage_state_t;

endpackage

// File: rtl/deco_imm_stage_ctrl_imm_extend.sv
// Combinational immediate extender: widens the raw immediate field per selected format.
module imm_extend_unit
  import deco_pkg::*;
#(
  parameter int INTEGER_WIDTH = deco_pkg::INTEGER_WIDTH,
  parameter int IMM_WIDTH     = deco_pkg::IMM_WIDTH
) (
  input  logic [IMM_WIDTH-1:0]     imm,
  input  imm_sel_t                 sel,
  output logic [INTEGER_WIDTH-1:0] ext
);

  localparam int PAD_W = INTEGER_WIDTH - IMM_WIDTH;

  always_comb begin
    ext = '0;
    unique case (sel)
      SEXT:    ext = {{PAD_W{imm[IMM_WIDTH-1]}}, imm};
      ZEXT:    ext = {{PAD_W{1'b0}}, imm};
      UPPER:   ext = {imm, {PAD_W{1'b0}}};
      NONE:    ext = '0;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/deco_imm_stage_ctrl.sv
// Decode-stage controller: 2-entry skid buffer carrying instruction plus extended
// immediate toward execute, with hazard stall, flush and a saturating stall counter.
module deco_imm_stage_ctrl
  import deco_pkg::*;
#(
  parameter int INTEGER_WIDTH = deco_pkg::INTEGER_WIDTH,
  parameter int IMM_WIDTH     = deco_pkg::IMM_WIDTH,
  parameter int INSTR_WIDTH   = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [1:0]               in_imm_sel,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [INTEGER_WIDTH-1:0] out_imm,
  input  logic                     out_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [CNT_WIDTH-1:0]     stall_cnt
);

  stage_state_t             state;
  logic [INSTR_WIDTH-1:0]   main_instr, skid_instr;
  logic [INTEGER_WIDTH-1:0] main_imm, skid_imm;
  logic [INTEGER_WIDTH-1:0] ext_imm;
  logic                     in_fire, out_fire;

  imm_extend_unit #(
    .INTEGER_WIDTH(INTEGER_WIDTH),
    .IMM_WIDTH    (IMM_WIDTH)
  ) u_imm_extend (
    .imm(in_instr[IMM_WIDTH-1:0]),
    .sel(imm_sel_t'(in_imm_sel)),
    .ext(ext_imm)
  );

  assign out_valid = (state != EMPTY);
  assign out_instr = main_instr;
  assign out_imm   = main_imm;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready & ~stall;

  // in_ready is written with the next-state value so it never depends on out_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      main_instr <= '0;
      main_imm   <= '0;
      skid_instr <= '0;
      skid_imm   <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_instr <= in_instr;
            main_imm   <= ext_imm;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_instr <= in_instr;
            main_imm   <= ext_imm;
          end else if (in_fire) begin
            skid_instr <= in_instr;
            skid_imm   <= ext_imm;
            state      <= FULL;
            in_ready   <= 1'b0;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_instr <= skid_instr;
            main_imm   <= skid_imm;
            state      <= ONE;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && stall && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_deco_imm_stage_ctrl.sv
// Self-checking bench: queue-based reference of the decode stage, directed and random traffic.
module tb_deco_imm_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [1:0]  in_imm_sel;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic        out_ready;
  logic        stall;
  logic        flush;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q_instr[$];
  logic [31:0] q_imm[$];
  logic [31:0] shown_instr, shown_imm;
  int unsigned cnt_m;

  deco_imm_stage_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_imm_sel(in_imm_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_imm   (out_imm),
    .out_ready (out_ready),
    .stall     (stall),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] ins, input logic [1:0] sel);
    int unsigned v;
    v = ins & 32'h7FFFF;
    case (sel)
      2'd0:    return (v >= 32'd262144) ? v - 32'd524288 : v;
      2'd1:    return v;
      2'd2:    return v * 32'd8192;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [18:0] imm);
    logic [31:0] r;
    r = $urandom;
    r[18:0] = imm;
    return r;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, q_instr.size() > 0);
    chk("in_ready", in_ready, q_instr.size() < 2);
    chk("stall_cnt", stall_cnt, cnt_m);
    chk("out_instr", out_instr, shown_instr);
    chk("out_imm", out_imm, shown_imm);
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [1:0] sel,
                      input logic ordy, input logic stl, input logic fl);
    bit f_in, f_out;
    in_valid = iv; in_instr = ins; in_imm_sel = sel;
    out_ready = ordy; stall = stl; flush = fl;
    @(posedge clk);
    f_in  = iv && (q_instr.size() < 2);
    f_out = (q_instr.size() > 0) && ordy && !stl;
    if ((q_instr.size() > 0) && stl && cnt_m != 32'hFFFF) cnt_m++;
    if (fl) begin
      q_instr.delete();
      q_imm.delete();
    end else begin
      if (f_out) begin
        void'(q_instr.pop_front());
        void'(q_imm.pop_front());
      end
      if (f_in) begin
        q_instr.push_back(ins);
        q_imm.push_back(ref_ext(ins, sel));
      end
    end
    if (q_instr.size() > 0) begin
      shown_instr = q_instr[0];
      shown_imm   = q_imm[0];
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 2'd0, ordy, 1'b0, 1'b0);
  endtask

  // asserts reset away from a clock edge, checks the asynchronous effect, releases on a negedge
  task automatic do_reset();
    in_valid = 0; in_instr = 0; in_imm_sel = 0; out_ready = 0; stall = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    q_instr.delete();
    q_imm.delete();
    cnt_m = 0; shown_instr = 0; shown_imm = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] a, b, c;

  initial begin
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();
    idle(1'b1);

    // stall holds the single entry and counts cycles
    a = mk(19'd12345);
    step(1'b1, a, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("sext_pos", out_imm, 32'h0000_3039);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("stall_cnt_5", stall_cnt, 16'd5);
    chk("stall_hold_instr", out_instr, a);
    step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("stall_release", out_valid, 1'b0);

    // formats, chained through simultaneous in/out transfers
    step(1'b1, mk(19'h72BCF), 2'd0, 1'b0, 1'b0, 1'b0);
    chk("sext_neg", out_imm, 32'hFFFF_2BCF);
    step(1'b1, mk(19'h72BCF), 2'd1, 1'b1, 1'b0, 1'b0);
    chk("zext", out_imm, 32'h0007_2BCF);
    step(1'b1, mk(19'h00001), 2'd2, 1'b1, 1'b0, 1'b0);
    chk("upper", out_imm, 32'h0000_2000);
    step(1'b1, mk(19'h7FFFF), 2'd3, 1'b1, 1'b0, 1'b0);
    chk("none", out_imm, 32'h0);
    idle(1'b1);

    // back-pressure: A, B fill the buffer, C waits at the input
    a = $urandom; b = $urandom; c = $urandom;
    step(1'b1, a, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("bp_full_ready", in_ready, 1'b0);
    step(1'b1, c, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("bp_head_a", out_instr, a);
    step(1'b1, c, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("bp_head_b", out_instr, b);
    step(1'b1, c, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("bp_head_c", out_instr, c);
    idle(1'b1);
    idle(1'b1);

    // flush from FULL with a same-cycle input
    step(1'b1, $urandom, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 2'd2, 1'b1, 1'b0, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // reset while FULL and stalled
    step(1'b1, $urandom, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle(1'b0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, $urandom, 2'($urandom % 4), 1'($urandom % 2),
           ($urandom % 5) == 0, ($urandom % 40) == 0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
